// File: rtl/fir_coef_loader.sv
// Byte-serial coefficient frame receiver for fir_core: assembles, checksums and
// burst-writes NUM_TAPS coefficients, so that a bad or stalled frame never reaches the FIR.
module fir_coef_loader #(
  parameter int         NUM_TAPS  = 64,
  parameter int         ADDR_W    = 6,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [15:0]       cin,
  output logic [ADDR_W-1:0] caddr,
  output logic              cload,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int GW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RX_HI,
    RX_LO,
    CHK,
    WRITE
  } state_t;

  state_t            state_q;
  logic [7:0]        hiByte_q;
  logic [7:0]        runXor_q;
  logic [ADDR_W-1:0] byteIdx_q;
  logic [GW-1:0]     gapCnt_q;
  logic              sReady_q;
  logic [15:0]       cin_q;
  logic [ADDR_W-1:0] caddr_q;
  logic              cload_q;
  logic              busy_q;
  logic              loadDone_q;
  logic              loadErr_q;
  logic [15:0]       shadow_q [NUM_TAPS];

  logic xfer;
  logic rxActive;
  logic gapExpired;

  assign xfer       = s_valid & sReady_q;
  assign rxActive   = (state_q == RX_HI) || (state_q == RX_LO) || (state_q == CHK);
  assign gapExpired = rxActive && !xfer && (gapCnt_q == GW'(TIMEOUT - 1));

  // Shadow buffer has no reset: it is only ever read after a full frame has refilled it.
  always_ff @(posedge clk2) begin
    if (state_q == RX_LO && xfer) begin
      shadow_q[byteIdx_q] <= {hiByte_q, s_data};
    end
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hiByte_q   <= '0;
      runXor_q   <= '0;
      byteIdx_q  <= '0;
      gapCnt_q   <= '0;
      sReady_q   <= 1'b1;
      cin_q      <= '0;
      caddr_q    <= '0;
      cload_q    <= 1'b0;
      busy_q     <= 1'b0;
      loadDone_q <= 1'b0;
      loadErr_q  <= 1'b0;
    end else begin
      loadDone_q <= 1'b0;
      loadErr_q  <= 1'b0;

      if (rxActive) begin
        gapCnt_q <= xfer ? '0 : gapCnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (xfer && s_data == SYNC_BYTE) begin
            byteIdx_q <= '0;
            runXor_q  <= '0;
            gapCnt_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= RX_HI;
          end
        end

        RX_HI: begin
          if (xfer) begin
            hiByte_q <= s_data;
            runXor_q <= runXor_q ^ s_data;
            state_q  <= RX_LO;
          end
        end

        RX_LO: begin
          if (xfer) begin
            runXor_q <= runXor_q ^ s_data;
            if (byteIdx_q == ADDR_W'(NUM_TAPS - 1)) begin
              state_q <= CHK;
            end else begin
              byteIdx_q <= byteIdx_q + 1'b1;
              state_q   <= RX_HI;
            end
          end
        end

        // First strobe is issued straight from the checksum edge so cload spans exactly NUM_TAPS cycles.
        CHK: begin
          if (xfer) begin
            if (s_data == runXor_q) begin
              sReady_q <= 1'b0;
              cload_q  <= 1'b1;
              caddr_q  <= '0;
              cin_q    <= shadow_q[0];
              state_q  <= WRITE;
            end else begin
              loadErr_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end

        WRITE: begin
          if (caddr_q == ADDR_W'(NUM_TAPS - 1)) begin
            cload_q    <= 1'b0;
            loadDone_q <= 1'b1;
            sReady_q   <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            caddr_q <= caddr_q + 1'b1;
            cin_q   <= shadow_q[caddr_q + 1'b1];
          end
        end

        default: begin
          sReady_q <= 1'b1;
          cload_q  <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase

      if (gapExpired) begin
        loadErr_q <= 1'b1;
        busy_q    <= 1'b0;
        state_q   <= IDLE;
      end
    end
  end

  assign s_ready   = sReady_q;
  assign cin       = cin_q;
  assign caddr     = caddr_q;
  assign cload     = cload_q;
  assign busy      = busy_q;
  assign load_done = loadDone_q;
  assign load_err  = loadErr_q;

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Upstream coefficient-programming stage for fir_core, in the clk2 (100 MHz) domain.
- Receives a byte-serial coefficient frame over a valid/ready stream and assembles 16-bit signed coefficients into a NUM_TAPS-entry shadow buffer.
- Checks a frame checksum, then burst-writes the buffer into fir_core through cin/caddr/cload.
- A corrupt or stalled frame never reaches the FIR's coefficient memory.

Parameters:
- NUM_TAPS, 64, number of coefficients per frame; matches fir_core.
- ADDR_W, 6, caddr width; equals clog2(NUM_TAPS).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1024, maximum idle clk2 cycles between frame bytes before abort.

Ports:
- clk2  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  8  frame byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a byte; a transfer occurs when s_valid & s_ready.
- cin  out  16  coefficient to fir_core.
- caddr  out  ADDR_W  coefficient address to fir_core.
- cload  out  1  coefficient write strobe to fir_core.
- busy  out  1  high in any state other than IDLE.
- load_done  out  1  one-cycle pulse; frame committed to fir_core.
- load_err  out  1  one-cycle pulse; frame rejected (bad checksum or timeout).

Behaviour:
- Reset values: s_ready=1, cin=0, caddr=0, cload=0, busy=0, load_done=0, load_err=0, state=IDLE. Shadow buffer is not reset.
- Frame format: SYNC_BYTE, then NUM_TAPS coefficients as hi byte followed by lo byte (coefficient 0 first), then one checksum byte. Checksum = XOR of all 2*NUM_TAPS coefficient bytes; the sync byte is excluded.
- IDLE: s_ready=1. A transfer of SYNC_BYTE clears the byte index and running XOR, then moves to RX_HI. Any other byte is consumed and discarded.
- RX_HI: on transfer, latch hi byte, XOR into checksum, move to RX_LO.
- RX_LO: on transfer, write {hi,lo} to shadow[index] and XOR into checksum. If index==NUM_TAPS-1, move to CHK; otherwise increment index and move to RX_HI.
- CHK: on transfer, compare the byte to the running XOR.
  - Match: move to WRITE.
  - Mismatch: pulse load_err the next cycle, return to IDLE, no cload activity.
- Gap timer: counts cycles in RX_HI, RX_LO or CHK with no transfer; clears on each transfer. Reaching TIMEOUT pulses load_err and returns to IDLE.
- WRITE: s_ready=0; input bytes are held off, not dropped.
  - Drives cload=1 for exactly NUM_TAPS consecutive cycles with caddr=k, cin=shadow[k], k=0..NUM_TAPS-1, all outputs registered.
  - On the cycle after the last strobe: cload=0, load_done=1 for one cycle, return to IDLE.
- Latency: checksum byte accepted at edge T gives cload high for cycles T+1..T+NUM_TAPS and load_done high at cycle T+NUM_TAPS+1. Total frame cost is 2*NUM_TAPS+2 transfers plus NUM_TAPS+1 cycles.
- s_ready is 1 in IDLE, RX_HI, RX_LO and CHK; 0 in WRITE. It is a function of the registered state only; there is no combinational path from s_valid.
- A sync byte received mid-frame is treated as data; there is no resynchronisation except via timeout or error.
- cin/caddr hold their last values when cload=0.
- load_done and load_err are never high in the same cycle.
- busy = (state != IDLE).
- Reset asserted mid-frame or mid-WRITE: all outputs immediately return to their reset values (cload drops asynchronously) and the partial frame is discarded. fir_core keeps any coefficients already written.

Test Plan:
- Reset for 10 cycles, then idle -> s_ready=1, cload=0, busy=0, no pulses.
- Frame: A5, 64×{01,00}, checksum 00 -> 64 consecutive cload cycles with caddr 0..63 and cin=16'h0100; load_done one cycle later; busy low after.
- Same frame with checksum FF -> load_err pulse one cycle after the checksum byte; cload never asserted; next valid frame loads normally.
- Bytes 00,3C before A5, and s_valid toggled randomly within the frame (coefficient k = 16'hF000+k, checksum = XOR of its bytes) -> garbage discarded; cin values F000..F03F written in order.
- Stop after 10 coefficient bytes, wait 1024 cycles -> load_err at the timeout; state IDLE; no cload.
- Assert rst at the 20th cload cycle -> cload=0 within the same cycle; after release a full valid frame completes with load_done.
